// File: rtl/agm_pingpong.sv
// N-bank ping-pong BRAM address generator: narrow sequential writer, RATIO-wide reader.
// A bank becomes readable once it is completely written, and writable again once it is completely drained.
module agm_pingpong #(
    parameter int NUM_BANKS     = 2,
    parameter int BANK_DEPTH_WR = 1024,
    parameter int RATIO         = 4,
    parameter int CNT_W         = 9
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              en_wr,
    input  logic                                              en_rd,
    output logic                                              wr_ready,
    output logic                                              pause,
    output logic                                              wea,
    output logic [$clog2(NUM_BANKS*BANK_DEPTH_WR)-1:0]        W_BRAM_ADDR,
    output logic [$clog2(NUM_BANKS*(BANK_DEPTH_WR/RATIO))-1:0] R_BRAM_ADDR,
    output logic                                              rd_valid,
    output logic [$clog2(NUM_BANKS)-1:0]                      sel,
    output logic [$clog2(NUM_BANKS)-1:0]                      wr_bank,
    output logic                                              start,
    output logic                                              overflow,
    output logic [CNT_W-1:0]                                  count
);

    localparam int BANK_W   = $clog2(NUM_BANKS);
    localparam int RD_DEPTH = BANK_DEPTH_WR / RATIO;
    localparam int WP_W     = $clog2(BANK_DEPTH_WR);
    localparam int RP_W     = $clog2(RD_DEPTH);

    logic [WP_W-1:0]      wr_ptr;
    logic [RP_W-1:0]      rd_ptr;
    logic [BANK_W-1:0]    rd_bank;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_next;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wr_last;
    logic                 rd_last;

    assign wr_ready = !full[wr_bank];
    assign sel      = rd_bank;
    assign wr_acc   = en_wr && wr_ready;
    assign rd_acc   = en_rd && full[rd_bank];
    // Depths are powers of two, so the last word of a bank is the all-ones pointer.
    assign wr_last  = wr_acc && (&wr_ptr);
    assign rd_last  = rd_acc && (&rd_ptr);

    // Set and clear never target the same bank: set needs !full, clear needs full.
    always_comb begin
        full_next = full;
        if (wr_last) full_next[wr_bank] = 1'b1;
        if (rd_last) full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_bank     <= '0;
            rd_bank     <= '0;
            full        <= '0;
            wea         <= 1'b0;
            rd_valid    <= 1'b0;
            W_BRAM_ADDR <= '0;
            R_BRAM_ADDR <= '0;
            start       <= 1'b0;
            overflow    <= 1'b0;
            pause       <= 1'b0;
            count       <= '0;
        end else begin
            pause <= en_wr && !wr_ready;
            if (en_wr && !wr_ready) overflow <= 1'b1;

            wea <= wr_acc;
            if (wr_acc) begin
                W_BRAM_ADDR <= {wr_bank, wr_ptr};
                wr_ptr      <= wr_ptr + 1'b1;
                if (wr_last) begin
                    wr_bank <= wr_bank + 1'b1;
                    start   <= 1'b1;
                end
            end

            rd_valid <= rd_acc;
            if (rd_acc) begin
                R_BRAM_ADDR <= {rd_bank, rd_ptr};
                rd_ptr      <= rd_ptr + 1'b1;
                if (rd_last) begin
                    rd_bank <= rd_bank + 1'b1;
                    count   <= count + 1'b1;
                end
            end

            full <= full_next;
        end
    end

endmodule

// File: doc/agm_pingpong.md
Name: agm_pingpong

Overview:
- Single-clock, parametrised BRAM address generator for N-bank ping-pong line buffering in the image pipeline.
- The narrow write port fills banks sequentially. The wide read port, RATIO times wider, drains each full bank and then releases it back to the writer.
- Provides backpressure, bank-full tracking, sticky overflow and a drained-bank counter.
- Drives the dual-port line BRAM between the pixel input stage and the filter stage.

Parameters:
- NUM_BANKS, 2, number of ping-pong banks; power of two, >=2.
- BANK_DEPTH_WR, 1024, write-side words per bank; power of two.
- RATIO, 4, write words per read word; power of two, divides BANK_DEPTH_WR.
- CNT_W, 9, width of the drained-bank counter.
- Derived (localparam): BANK_W=clog2(NUM_BANKS); WR_AW=clog2(NUM_BANKS*BANK_DEPTH_WR); RD_DEPTH=BANK_DEPTH_WR/RATIO; RD_AW=clog2(NUM_BANKS*RD_DEPTH).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- en_wr  in  1  write request; one pixel word this cycle.
- en_rd  in  1  read request; one read word this cycle.
- wr_ready  out  1  combinational: current write bank not full.
- pause  out  1  registered: en_wr was high while wr_ready was low last cycle (stall indicator).
- wea  out  1  BRAM write enable, registered.
- W_BRAM_ADDR  out  WR_AW  BRAM write address, registered.
- R_BRAM_ADDR  out  RD_AW  BRAM read address, registered.
- rd_valid  out  1  R_BRAM_ADDR is a live read this cycle.
- sel  out  BANK_W  current read bank.
- wr_bank  out  BANK_W  current write bank.
- start  out  1  sticky; set when the first bank becomes full.
- overflow  out  1  sticky; set on en_wr while wr_ready is low.
- count  out  CNT_W  banks fully drained, wraps modulo 2^CNT_W.

Behaviour:
- State:
  - wr_ptr[clog2(BANK_DEPTH_WR)], rd_ptr[clog2(RD_DEPTH)].
  - wr_bank, rd_bank (sel).
  - full[NUM_BANKS] flags.
- Reset (sync, any time, including mid-bank):
  - wea=0, rd_valid=0, W_BRAM_ADDR=0, R_BRAM_ADDR=0.
  - pointers, banks, count = 0; full=0; start=0; overflow=0; pause=0.
  - Reset has priority over all other events.
- wr_ready = !full[wr_bank].
- Write accept (en_wr && wr_ready), next edge:
  - wea=1; W_BRAM_ADDR = {wr_bank, wr_ptr}; wr_ptr++. Latency is 1 cycle.
  - If wr_ptr was BANK_DEPTH_WR-1: wr_ptr=0, full[wr_bank]=1, wr_bank=(wr_bank+1) mod NUM_BANKS, start=1.
- No accept: wea=0. W_BRAM_ADDR holds its last value; it is never X.
- en_wr && !wr_ready: overflow=1 (sticky until reset), pause=1 for that cycle's registered output. The word is dropped and pointers do not move.
- Read accept (en_rd && full[rd_bank]), next edge:
  - rd_valid=1; R_BRAM_ADDR = {rd_bank, rd_ptr}; rd_ptr++.
  - If rd_ptr was RD_DEPTH-1: rd_ptr=0, full[rd_bank]=0, rd_bank++ mod NUM_BANKS, count++ (wraps).
- No read accept, including en_rd with the current bank not full: rd_valid=0, R_BRAM_ADDR holds.
- Simultaneous write bank-complete and read bank-release act on different banks; both updates apply in the same edge.
  - Same-bank set and clear is impossible: set requires !full and clear requires full.
- A bank released by the reader on edge t may be written from edge t+1 (wr_ready rises combinationally after edge t).
- Read-after-write ordering:
  - The final write of a bank reaches the BRAM on the edge after its address is registered.
  - The earliest read address is registered on that same edge, so the BRAM sees the read one edge later. No hazard.
- All pointer arithmetic is power-of-two wrap; no modulo operators on non-power-of-two values.

Test Plan:
- Defaults, reset, then en_wr held for 1024 cycles -> W_BRAM_ADDR 0..1023 with wea=1; start=1 and wr_bank=1 after the 1024th accept; full[0]=1.
- Then en_rd held for 256 cycles -> R_BRAM_ADDR 0..255 with rd_valid=1, each 1 cycle after its accept; count=1, sel=1, bank 0 released.
- Write 2048 words with en_rd=0, then 3 more en_wr -> wr_ready=0, overflow=1, pause pulses; W_BRAM_ADDR holds 2047, wea=0.
- Concurrent: writer finishes bank 1 on the same edge the reader finishes bank 0 -> full becomes {1:1, 0:0}, wr_bank=0, sel=1, count increments once.
- Reset asserted at write word 500 / read word 100 -> next cycle all outputs are at reset values; a subsequent write restarts at address 0.
- NUM_BANKS=4, RATIO=2, BANK_DEPTH_WR=64, CNT_W=2 -> bank 3 write addresses are 192..255; after 5 drained banks count=1 (wrap).
